// File: rtl/emu_ctrl_pkg.sv
// Shared types and default widths for the emulator control block.
// Mode encoding matches the host control word written by sim_ctrl_gen/VIO.
package emu_ctrl_pkg;

    localparam int DEF_DT_WIDTH   = 32;
    localparam int DEF_TIME_WIDTH = 64;
    localparam int DEF_DEC_WIDTH  = 24;

    // Largest stall request at the default timestep width.
    localparam logic [DEF_DT_WIDTH-1:0] DT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_STOP = 2'd1,
        MODE_ABS  = 2'd2,
        MODE_REL  = 2'd3
    } emu_ctrl_mode_t;

    function automatic logic is_target_mode(input emu_ctrl_mode_t mode);
        return (mode == MODE_ABS) || (mode == MODE_REL);
    endfunction

endpackage

// File: rtl/emu_dec_counter.sv
// Trace decimation counter: strobes once every emu_dec_thr+1 cycles.
// Built only when EMU_DEC_EN is defined; otherwise the strobe is tied high.
module emu_dec_counter
    import emu_ctrl_pkg::*;
#(
    parameter int DEC_WIDTH = DEF_DEC_WIDTH
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst,
    input  logic [DEC_WIDTH-1:0] emu_dec_thr,
    output logic                 emu_dec_cmp
);

`ifdef EMU_DEC_EN
    logic [DEC_WIDTH-1:0] dec_cnt;
    logic                 dec_hit;

    // Greater-or-equal so that a threshold lowered under the running count fires at once.
    always_comb begin
        dec_hit = (dec_cnt >= emu_dec_thr);
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            dec_cnt <= '0;
        end else if (dec_hit) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + DEC_WIDTH'(1);
        end
    end

    assign emu_dec_cmp = dec_hit;
`else
    logic unused_dec_inputs;

    assign unused_dec_inputs = ^{emu_clk, emu_rst, emu_dec_thr};
    assign emu_dec_cmp       = 1'b1;
`endif

endmodule

// File: rtl/emu_clk_ctrl.sv
// Emulation control: host mode/data to stall timestep, trace decimation strobe,
// and default-oscillator gate enable. Decimation counter depends on EMU_DEC_EN.
module emu_clk_ctrl
    import emu_ctrl_pkg::*;
#(
    parameter int DT_WIDTH   = DEF_DT_WIDTH,
    parameter int TIME_WIDTH = DEF_TIME_WIDTH,
    parameter int DEC_WIDTH  = DEF_DEC_WIDTH
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic [1:0]            emu_ctrl_mode,
    input  logic [TIME_WIDTH-1:0] emu_ctrl_data,
    input  logic [TIME_WIDTH-1:0] emu_time,
    input  logic [DEC_WIDTH-1:0]  emu_dec_thr,
    input  logic                  clk_val_default_osc,
    output logic [DT_WIDTH-1:0]   dt_req_stall,
    output logic                  emu_dec_cmp,
    output logic                  clk_default_osc_en
);

    localparam logic [DT_WIDTH-1:0] DT_SAT = '1;

    emu_ctrl_mode_t        mode_q;
    emu_ctrl_mode_t        mode_prev_q;
    logic [TIME_WIDTH-1:0] data_q;
    logic [TIME_WIDTH-1:0] data_prev_q;
    logic [TIME_WIDTH-1:0] target_q;
    logic [TIME_WIDTH-1:0] rel_target;
    logic [TIME_WIDTH-1:0] active_target;
    logic [TIME_WIDTH-1:0] time_left;
    logic                  rel_load;
    logic                  osc_en_q;

    // The previous-cycle copies let us spot REL entry and data edits while in REL.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            mode_q      <= MODE_RUN;
            mode_prev_q <= MODE_RUN;
            data_q      <= '0;
            data_prev_q <= '0;
        end else begin
            mode_q      <= emu_ctrl_mode_t'(emu_ctrl_mode);
            mode_prev_q <= mode_q;
            data_q      <= emu_ctrl_data;
            data_prev_q <= data_q;
        end
    end

    always_comb begin
        rel_target = emu_time + data_q;
        rel_load   = (mode_q == MODE_REL) &&
                     ((mode_prev_q != MODE_REL) || (data_q != data_prev_q));
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            target_q <= '0;
        end else if (rel_load) begin
            target_q <= rel_target;
        end
    end

    // During the REL load cycle the fresh sum is used so the stall is never stale.
    always_comb begin
        dt_req_stall  = DT_SAT;
        active_target = data_q;
        time_left     = '0;
        unique case (mode_q)
            MODE_RUN:  active_target = data_q;
            MODE_STOP: active_target = data_q;
            MODE_ABS:  active_target = data_q;
            MODE_REL:  active_target = rel_load ? rel_target : target_q;
            default:   active_target = data_q;
        endcase
        if (mode_q == MODE_STOP) begin
            dt_req_stall = '0;
        end else if (is_target_mode(mode_q)) begin
            if (emu_time >= active_target) begin
                dt_req_stall = '0;
            end else begin
                time_left = active_target - emu_time;
                if (|time_left[TIME_WIDTH-1:DT_WIDTH]) begin
                    dt_req_stall = DT_SAT;
                end else begin
                    dt_req_stall = time_left[DT_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            osc_en_q <= 1'b0;
        end else begin
            osc_en_q <= clk_val_default_osc;
        end
    end

    assign clk_default_osc_en = osc_en_q;

    emu_dec_counter #(
        .DEC_WIDTH(DEC_WIDTH)
    ) u_dec_counter (
        .emu_clk     (emu_clk),
        .emu_rst     (emu_rst),
        .emu_dec_thr (emu_dec_thr),
        .emu_dec_cmp (emu_dec_cmp)
    );

endmodule

// File: tb/tb_emu_clk_ctrl.sv
// Directed bench for emu_clk_ctrl: per-cycle vector table for mode/stall and
// oscillator enable, hand sequences for decimation and asynchronous reset.
module tb_emu_clk_ctrl;
    import emu_ctrl_pkg::*;

`ifdef EMU_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic        emu_clk;
    logic        emu_rst;
    logic [1:0]  emu_ctrl_mode;
    logic [63:0] emu_ctrl_data;
    logic [63:0] emu_time;
    logic [23:0] emu_dec_thr;
    logic        clk_val_default_osc;
    logic [31:0] dt_req_stall;
    logic        emu_dec_cmp;
    logic        clk_default_osc_en;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        emu_ctrl_mode_t mode;
        logic [63:0]    data;
        logic [63:0]    tim;
        logic           osc;
        logic           chk_dt;
        logic [31:0]    exp_dt;
        logic           exp_en;
    } vec_t;

    vec_t vq[$];

    emu_clk_ctrl dut (
        .emu_clk             (emu_clk),
        .emu_rst             (emu_rst),
        .emu_ctrl_mode       (emu_ctrl_mode),
        .emu_ctrl_data       (emu_ctrl_data),
        .emu_time            (emu_time),
        .emu_dec_thr         (emu_dec_thr),
        .clk_val_default_osc (clk_val_default_osc),
        .dt_req_stall        (dt_req_stall),
        .emu_dec_cmp         (emu_dec_cmp),
        .clk_default_osc_en  (clk_default_osc_en)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    task automatic tick();
        @(posedge emu_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        emu_ctrl_mode       = 2'(v.mode);
        emu_ctrl_data       = v.data;
        emu_time            = v.tim;
        clk_val_default_osc = v.osc;
    endtask

    // Row i: inputs driven in cycle i, outputs expected in that same cycle.
    task automatic addVec(input emu_ctrl_mode_t m, input logic [63:0] d, input logic [63:0] t,
                          input logic o, input logic c, input logic [31:0] e, input logic en);
        vec_t v;
        v.mode = m; v.data = d; v.tim = t; v.osc = o;
        v.chk_dt = c; v.exp_dt = e; v.exp_en = en;
        vq.push_back(v);
    endtask

    initial begin
        addVec(MODE_RUN,  64'd0,          64'd0,    1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        addVec(MODE_STOP, 64'd0,          64'd0,    1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        addVec(MODE_STOP, 64'd0,          64'd0,    1'b0, 1'b1, 32'd0,         1'b0);
        addVec(MODE_RUN,  64'd0,          64'd0,    1'b0, 1'b1, 32'd0,         1'b0);
        addVec(MODE_RUN,  64'd0,          64'd0,    1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        addVec(MODE_ABS,  64'd1000,       64'd400,  1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        addVec(MODE_ABS,  64'd1000,       64'd400,  1'b0, 1'b1, 32'd600,       1'b0);
        addVec(MODE_ABS,  64'd1000,       64'd1000, 1'b0, 1'b1, 32'd0,         1'b0);
        addVec(MODE_ABS,  64'd1000,       64'd1200, 1'b0, 1'b1, 32'd0,         1'b0);
        addVec(MODE_ABS,  64'd1000,       64'd999,  1'b0, 1'b1, 32'd1,         1'b0);
        addVec(MODE_ABS,  64'd1 << 40,    64'd0,    1'b0, 1'b1, 32'd1000,      1'b0);
        addVec(MODE_ABS,  64'd1 << 40,    64'd0,    1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        addVec(MODE_ABS,  64'hFFFF_FFFF,  64'd0,    1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        addVec(MODE_ABS,  64'h1_0000_0000, 64'd1,   1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        addVec(MODE_ABS,  64'h1_0000_0000, 64'd0,   1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        addVec(MODE_REL,  64'd500,        64'd300,  1'b0, 1'b1, 32'hFFFF_FED4, 1'b0);
        addVec(MODE_REL,  64'd500,        64'd300,  1'b1, 1'b0, 32'd0,         1'b0);
        addVec(MODE_REL,  64'd500,        64'd300,  1'b1, 1'b1, 32'd500,       1'b1);
        addVec(MODE_REL,  64'd500,        64'd500,  1'b0, 1'b1, 32'd300,       1'b1);
        addVec(MODE_REL,  64'd100,        64'd700,  1'b0, 1'b1, 32'd100,       1'b0);
        addVec(MODE_REL,  64'd100,        64'd700,  1'b0, 1'b0, 32'd0,         1'b0);
        addVec(MODE_REL,  64'd100,        64'd700,  1'b0, 1'b1, 32'd100,       1'b0);
        addVec(MODE_REL,  64'd300,        64'd750,  1'b0, 1'b1, 32'd50,        1'b0);
        addVec(MODE_REL,  64'd300,        64'd750,  1'b0, 1'b0, 32'd0,         1'b0);
        addVec(MODE_REL,  64'd300,        64'd760,  1'b0, 1'b1, 32'd290,       1'b0);
        addVec(MODE_REL,  64'd300,        64'd1050, 1'b0, 1'b1, 32'd0,         1'b0);
        addVec(MODE_REL,  64'd300,        64'd1100, 1'b0, 1'b1, 32'd0,         1'b0);
        addVec(MODE_ABS,  64'd300,        64'd0,    1'b0, 1'b1, 32'd1050,      1'b0);
        addVec(MODE_REL,  64'd200,        64'd100,  1'b0, 1'b1, 32'd200,       1'b0);
        addVec(MODE_REL,  64'd200,        64'd100,  1'b0, 1'b0, 32'd0,         1'b0);
        addVec(MODE_REL,  64'd200,        64'd150,  1'b0, 1'b1, 32'd150,       1'b0);

        emu_rst             = 1'b1;
        emu_ctrl_mode       = 2'(MODE_RUN);
        emu_ctrl_data       = '0;
        emu_time            = '0;
        emu_dec_thr         = 24'd3;
        clk_val_default_osc = 1'b0;
        #1;
        checkOutput("reset dt", 64'(dt_req_stall), 64'(DT_MAX));
        checkOutput("reset osc_en", 64'(clk_default_osc_en), 64'd0);
        checkOutput("reset dec_cmp", 64'(emu_dec_cmp), DEC_EN ? 64'd0 : 64'd1);

        repeat (2) @(posedge emu_clk);
        #1;
        emu_rst = 1'b0;

        // Threshold 3: strobe on cycles 3, 7, 11 after release.
        for (int k = 0; k < 12; k++) begin
            #1;
            checkOutput($sformatf("dec thr3 cycle%0d", k), 64'(emu_dec_cmp),
                        (!DEC_EN || (k % 4 == 3)) ? 64'd1 : 64'd0);
            checkOutput($sformatf("run dt cycle%0d", k), 64'(dt_req_stall), 64'hFFFF_FFFF);
            tick();
        end

        emu_dec_thr = 24'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("dec thr0 cycle%0d", k), 64'(emu_dec_cmp), 64'd1);
            tick();
        end

        emu_dec_thr = 24'd10;
        for (int k = 0; k < 6; k++) begin
            #1;
            checkOutput($sformatf("dec thr10 cycle%0d", k), 64'(emu_dec_cmp),
                        DEC_EN ? 64'd0 : 64'd1);
            tick();
        end
        emu_dec_thr = 24'd4;
        #1;
        checkOutput("dec lowered thr", 64'(emu_dec_cmp), 64'd1);
        tick();
        #1;
        checkOutput("dec after lowered", 64'(emu_dec_cmp), DEC_EN ? 64'd0 : 64'd1);
        tick();

        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            #1;
            if (vq[i].chk_dt) begin
                checkOutput($sformatf("row%0d dt", i), 64'(dt_req_stall), 64'(vq[i].exp_dt));
            end
            checkOutput($sformatf("row%0d osc_en", i), 64'(clk_default_osc_en), 64'(vq[i].exp_en));
            tick();
        end

        clk_val_default_osc = 1'b1;
        tick();
        #1;
        checkOutput("pre-reset osc_en", 64'(clk_default_osc_en), 64'd1);
        checkOutput("pre-reset rel dt", 64'(dt_req_stall), 64'd150);
        #2;
        emu_rst = 1'b1;
        #1;
        checkOutput("async reset dt", 64'(dt_req_stall), 64'hFFFF_FFFF);
        checkOutput("async reset osc_en", 64'(clk_default_osc_en), 64'd0);
        checkOutput("async reset dec_cmp", 64'(emu_dec_cmp), DEC_EN ? 64'd0 : 64'd1);
        tick();
        emu_rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
